// File: rtl/mac_pkg.sv
// Shared constants and width helpers for the lane-parallel MAC column.
package mac_pkg;

  localparam int PSUM_GUARD = 6;

  function automatic int min_psum_width(input int bw, input int pr);
    return 2 * bw + $clog2(pr);
  endfunction

  function automatic bit psum_width_ok(input int bw, input int pr, input int bw_psum);
    return bw_psum >= min_psum_width(bw, pr);
  endfunction

endpackage

// File: rtl/mac_lanes_acc_if.sv
// Operand/result bundle for mac_lanes_acc; sat_flag exists only when MAC_SAT_EN is defined.
interface mac_lanes_acc_if
  import mac_pkg::*;
#(
  parameter int BW      = 8,
  parameter int PR      = 8,
  parameter int BW_PSUM = 2 * BW + PSUM_GUARD
);

  logic                in_valid;
  logic                in_last;
  logic                signed_mode;
  logic [PR*BW-1:0]    a;
  logic [PR*BW-1:0]    b;
  logic [BW_PSUM-1:0]  out;
  logic                out_valid;
  logic                out_last;
`ifdef MAC_SAT_EN
  logic                sat_flag;

  modport master (
    output in_valid, in_last, signed_mode, a, b,
    input  out, out_valid, out_last, sat_flag
  );

  modport slave (
    input  in_valid, in_last, signed_mode, a, b,
    output out, out_valid, out_last, sat_flag
  );
`else
  modport master (
    output in_valid, in_last, signed_mode, a, b,
    input  out, out_valid, out_last
  );

  modport slave (
    input  in_valid, in_last, signed_mode, a, b,
    output out, out_valid, out_last
  );
`endif

endinterface

// File: rtl/mac_lane_mul.sv
// One MAC lane: extends both operands by one bit (sign or zero) and registers the product.
module mac_lane_mul #(
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          signed_mode,
  input  logic [BW-1:0] a,
  input  logic [BW-1:0] b,
  output logic [2*BW:0] prod
);

  logic signed [2*BW:0] a_w;
  logic signed [2*BW:0] b_w;
  logic signed [2*BW:0] prod_next;

  // 2*BW+1 bits holds both -2^(BW-1) squared and (2^BW-1) squared as positive values
  assign a_w       = {{(BW+1){signed_mode & a[BW-1]}}, a};
  assign b_w       = {{(BW+1){signed_mode & b[BW-1]}}, b};
  assign prod_next = a_w * b_w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod <= '0;
    end else if (en) begin
      prod <= prod_next;
    end
  end

endmodule

// File: rtl/mac_lanes_acc.sv
// PR-lane dot product with optional cross-beat accumulation (ACC_MODE=1).
// Define MAC_SAT_EN to saturate the accumulator and expose sat_flag.
module mac_lanes_acc
  import mac_pkg::*;
#(
  parameter int BW       = 8,
  parameter int PR       = 8,
  parameter int BW_PSUM  = 2 * BW + PSUM_GUARD,
  parameter int ACC_MODE = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  mac_lanes_acc_if.slave  bus
);

  localparam int PW = 2 * BW + 1;

  if (!psum_width_ok(BW, PR, BW_PSUM)) begin : g_width_check
    $error("mac_lanes_acc: BW_PSUM=%0d below minimum %0d", BW_PSUM, min_psum_width(BW, PR));
  end

  logic [PW-1:0]      prod [PR];
  logic               v1;
  logic               l1;
  logic [BW_PSUM-1:0] sum;

  for (genvar i = 0; i < PR; i++) begin : g_lane
    mac_lane_mul #(.BW(BW)) u_mul (
      .clk         (clk),
      .reset_n     (reset_n),
      .en          (bus.in_valid),
      .signed_mode (bus.signed_mode),
      .a           (bus.a[BW*i +: BW]),
      .b           (bus.b[BW*i +: BW]),
      .prod        (prod[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0;
      l1 <= 1'b0;
    end else begin
      v1 <= bus.in_valid;
      l1 <= bus.in_last;
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < PR; i++) begin
      sum = sum + {{(BW_PSUM-PW){prod[i][PW-1]}}, prod[i]};
    end
  end

  if (ACC_MODE == 0) begin : g_direct

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        bus.out       <= '0;
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
`ifdef MAC_SAT_EN
        bus.sat_flag  <= 1'b0;
`endif
      end else begin
        bus.out_valid <= v1;
        bus.out_last  <= v1;
`ifdef MAC_SAT_EN
        bus.sat_flag  <= 1'b0;
`endif
        if (v1) begin
          bus.out <= sum;
        end
      end
    end

  end else begin : g_accum

    logic [BW_PSUM-1:0] acc;
    logic [BW_PSUM-1:0] acc_add;
    logic [BW_PSUM-1:0] acc_next;
    logic               group_open;
`ifdef MAC_SAT_EN
    logic [BW_PSUM:0]   wide;
    logic               sat_now;
    logic               sat_seen;

    // Overflow shows up as the two top bits of the one-bit-wider sum disagreeing
    always_comb begin
      wide    = {acc[BW_PSUM-1], acc} + {sum[BW_PSUM-1], sum};
      acc_add = wide[BW_PSUM-1:0];
      sat_now = 1'b0;
      if (group_open && (wide[BW_PSUM] != wide[BW_PSUM-1])) begin
        sat_now = 1'b1;
        acc_add = wide[BW_PSUM] ? {1'b1, {(BW_PSUM-1){1'b0}}} : {1'b0, {(BW_PSUM-1){1'b1}}};
      end
    end
`else
    assign acc_add = acc + sum;
`endif

    assign acc_next = group_open ? acc_add : sum;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        acc           <= '0;
        group_open    <= 1'b0;
        bus.out       <= '0;
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
`ifdef MAC_SAT_EN
        sat_seen      <= 1'b0;
        bus.sat_flag  <= 1'b0;
`endif
      end else begin
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
`ifdef MAC_SAT_EN
        bus.sat_flag  <= 1'b0;
`endif
        if (v1) begin
          acc        <= acc_next;
          group_open <= !l1;
`ifdef MAC_SAT_EN
          sat_seen   <= !l1 && (sat_seen || sat_now);
`endif
          if (l1) begin
            bus.out       <= acc_next;
            bus.out_valid <= 1'b1;
            bus.out_last  <= 1'b1;
`ifdef MAC_SAT_EN
            bus.sat_flag  <= sat_seen || sat_now;
`endif
          end
        end
      end
    end

  end

endmodule
